i_sram_like_bridge_nway: RTL
============================

Name: i_sram_like_bridge_nway

Overview:
- Parametrised successor of the single-request instruction-side SRAM → SRAM-like bridge.
- Converts the fetch stage's SRAM-style request (enable + address, stall-back) into a one-transaction-at-a-time SRAM-like read handshake.
- Returns WAYS instruction words per transaction, each with its own valid flag.
- Adds flush/cancel: a fetch killed in flight has its late response discarded. Sits between the fetch stage and the instruction cache/AXI bridge.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, instruction word width
- WAYS, 2, words returned per transaction (≥1); way 0 = word at inst_sram_addr

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_sram_en  in  1  fetch request
- inst_sram_addr  in  ADDR_W  fetch address; held stable by the fetch stage while i_stall=1
- flush  in  1  kill current fetch (branch/exception redirect)
- longest_stall  in  1  pipeline-wide stall; captured words are held while high
- inst_sram_rdata  out  WAYS*DATA_W  captured words, way i at bits [i*DATA_W +: DATA_W]
- inst_sram_rvalid  out  WAYS  per-way captured-valid
- i_stall  out  1  fetch not yet complete
- inst_req  out  1  SRAM-like request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  ADDR_W  = inst_sram_addr
- inst_wdata  out  DATA_W  constant 0
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  WAYS  per-way data returned; bit 0 marks the completion beat
- inst_rdata  in  WAYS*DATA_W  returned words

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, inst_sram_rdata=0, inst_sram_rvalid=0. Combinationally, inst_req=0 and i_stall=inst_sram_en.
- Transaction protocol:
  - At most one outstanding transaction.
  - All ways of a transaction return in one beat, flagged by inst_data_ok[0].
  - inst_data_ok[i>0]=0 on that beat means way i is unavailable (line crossing); its rvalid is cleared.
  - inst_data_ok seen in IDLE or DONE is ignored.
- FSM states: IDLE, WAIT_DATA, DONE, CANCEL.
- IDLE:
  - inst_req = inst_sram_en & ~flush.
  - req & addr_ok & data_ok[0] (same cycle) → DONE, capture.
  - req & addr_ok → WAIT_DATA.
  - Otherwise stay in IDLE with req held.
- WAIT_DATA (inst_req=0):
  - data_ok[0] & ~flush → DONE, capture.
  - data_ok[0] & flush → IDLE, no capture.
  - flush → CANCEL.
- CANCEL (inst_req=0):
  - data_ok[0] → IDLE, no capture, rdata/rvalid unchanged.
  - flush while in CANCEL has no extra effect.
- DONE (inst_req=0):
  - ~longest_stall | flush → IDLE.
  - A new request issues at the earliest in the following cycle.
- Capture, on the completion beat only:
  - rdata[i] ← inst_rdata[i] for every way with inst_data_ok[i]=1.
  - rvalid[i] ← inst_data_ok[i].
  - rvalid[0] is always 1 after a capture.
- Captured data stays stable through DONE and until the next capture. It is not cleared by flush.
- i_stall = inst_sram_en & (state != DONE), so it stays high through IDLE, WAIT_DATA and CANCEL.
- Latency with zero-wait bus: req in cycle 0, addr_ok+data_ok in cycle 0, DONE and i_stall=0 in cycle 1.
- Reset mid-transaction: state returns to IDLE at once. The bus side shares rst, so no stale response is expected. Any stale response is ignored as IDLE traffic only if it arrives before a new request is accepted.
- inst_sram_en falling while in WAIT_DATA does not abort; only flush aborts.

Decomposition:
- Shared package (i_bridge_pkg):
  - state enum {IDLE, WAIT_DATA, DONE, CANCEL}
  - SIZE_WORD=2'b10
  - default ADDR_W/DATA_W
- One sub-module, i_bridge_way_capture: per-way data register + valid bit with capture enable. Instantiated WAYS times by generate.

Test Plan:
- Zero-wait fetch, WAYS=2: en=1, addr=0xBFC00000; addr_ok=data_ok=2'b11 in cycle 0 with rdata {0x11111111,0x22222222} → cycle 1: i_stall=0, rdata way0=0x22222222, way1=0x11111111, rvalid=2'b11, inst_req=0.
- Delayed data: addr_ok in cycle 0, data_ok=2'b01 in cycle 3 → i_stall=1 for cycles 0–3, 0 in cycle 4; rvalid=2'b01; way1 data unchanged from previous capture.
- Flush in flight: flush in cycle 1 (WAIT_DATA), data_ok=2'b11 in cycle 2 with 0xDEADBEEF → no capture, rdata/rvalid keep old values. New req with addr 0xBFC00100 appears in cycle 3.
- longest_stall hold: completion in cycle 0, longest_stall=1 for cycles 1–4 → DONE, i_stall=0, inst_req=0 and rdata stable through cycle 4. New req in cycle 6 after longest_stall drops in cycle 5.
- Flush coincident with data_ok[0] in WAIT_DATA → IDLE next cycle, no capture, i_stall stays 1.
- Synchronous reset asserted in WAIT_DATA → next cycle state=IDLE, rdata=0, rvalid=0, inst_req=en.

Source files
------------

// File: rtl/i_bridge_pkg.sv
// -----------------------------------------------------------------------------
// i_bridge_pkg
// Shared definitions for the instruction-side SRAM -> SRAM-like bridge:
//   - bridge_state_e : transaction FSM states (IDLE, WAIT_DATA, DONE, CANCEL)
//   - SIZE_WORD      : SRAM-like transfer size code for a 32-bit word
//   - DEFAULT_ADDR_W / DEFAULT_DATA_W : default address and word widths
// -----------------------------------------------------------------------------
package i_bridge_pkg;

    localparam int         DEFAULT_ADDR_W = 32;
    localparam int         DEFAULT_DATA_W = 32;
    localparam logic [1:0] SIZE_WORD      = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2,
        CANCEL    = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/i_bridge_way_capture.sv
// -----------------------------------------------------------------------------
// i_bridge_way_capture
// Holds one captured instruction word plus its valid flag.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears word and valid)
//   capture_i  : completion beat of the current transaction
//   data_ok_i  : this way's word is present on the completion beat
//   data_i     : returned word for this way
//   data_o     : captured word
//   valid_o    : captured-valid flag
// -----------------------------------------------------------------------------
module i_bridge_way_capture
    import i_bridge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // On a completion beat the valid flag always follows data_ok, but the word
    // is only overwritten when it actually arrived; an unavailable way keeps
    // its previous contents and is simply marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (capture_i) begin
            valid_q <= data_ok_i;
            if (data_ok_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/i_sram_like_bridge_nway.sv
// -----------------------------------------------------------------------------
// i_sram_like_bridge_nway
// Turns the fetch stage's SRAM-style request (enable + address, stall back)
// into a single-outstanding SRAM-like read returning WAYS words per beat.
// A flush kills the fetch in flight; its late response is discarded.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   inst_sram_en      : fetch request
//   inst_sram_addr    : fetch address (stable while i_stall)
//   flush             : kill current fetch
//   longest_stall     : pipeline stall, holds completed fetch in DONE
//   inst_sram_rdata   : captured words, way i at [i*DATA_W +: DATA_W]
//   inst_sram_rvalid  : per-way captured-valid
//   i_stall           : fetch not yet complete
//   inst_req/wr/size/addr/wdata : SRAM-like request channel
//   inst_addr_ok      : address accepted
//   inst_data_ok      : per-way data present, bit 0 marks completion beat
//   inst_rdata        : returned words
// -----------------------------------------------------------------------------
module i_sram_like_bridge_nway
    import i_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int WAYS   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_sram_en,
    input  logic [ADDR_W-1:0]      inst_sram_addr,
    input  logic                   flush,
    input  logic                   longest_stall,
    output logic [WAYS*DATA_W-1:0] inst_sram_rdata,
    output logic [WAYS-1:0]        inst_sram_rvalid,
    output logic                   i_stall,
    output logic                   inst_req,
    output logic                   inst_wr,
    output logic [1:0]             inst_size,
    output logic [ADDR_W-1:0]      inst_addr,
    output logic [DATA_W-1:0]      inst_wdata,
    input  logic                   inst_addr_ok,
    input  logic [WAYS-1:0]        inst_data_ok,
    input  logic [WAYS*DATA_W-1:0] inst_rdata
);

    bridge_state_e state_q;
    bridge_state_e state_d;
    logic          reqIssue;
    logic          captureEn;

    // A request is only presented from IDLE, and never while reset or a flush
    // is active, so a killed fetch cannot start a new bus transaction.
    assign reqIssue = ~rst & (state_q == IDLE) & inst_sram_en & ~flush;

    // Next-state and capture decision. The completion beat is bit 0 of
    // data_ok; it is only honoured when a transaction is really outstanding
    // (or being accepted this very cycle), so stray beats in IDLE/DONE vanish.
    always_comb begin
        state_d   = state_q;
        captureEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqIssue && inst_addr_ok) begin
                    if (inst_data_ok[0]) begin
                        state_d   = DONE;
                        captureEn = 1'b1;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (inst_data_ok[0]) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DONE;
                        captureEn = 1'b1;
                    end
                end else if (flush) begin
                    state_d = CANCEL;
                end
            end
            CANCEL: begin
                if (inst_data_ok[0]) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!longest_stall || flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any transaction in flight straight to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One capture register per way, all sharing the completion-beat enable.
    for (genvar g = 0; g < WAYS; g++) begin : gWay
        i_bridge_way_capture #(
            .DATA_W (DATA_W)
        ) uWay (
            .clk       (clk),
            .rst       (rst),
            .capture_i (captureEn),
            .data_ok_i (inst_data_ok[g]),
            .data_i    (inst_rdata[g*DATA_W +: DATA_W]),
            .data_o    (inst_sram_rdata[g*DATA_W +: DATA_W]),
            .valid_o   (inst_sram_rvalid[g])
        );
    end

    // The fetch stage is released only while the completed fetch sits in DONE.
    assign i_stall    = inst_sram_en & (rst | (state_q != DONE));
    assign inst_req   = reqIssue;
    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_addr  = inst_sram_addr;
    assign inst_wdata = '0;

endmodule
